trade_z_engine: RTL and testbench



---
 rtl/trade_z_pkg.sv | 24 ++
 rtl/trade_z_engine_isqrt_seq.sv | 65 ++++++
 rtl/trade_z_engine.sv | 191 +++++++++++++++++++
 tb/tb_trade_z_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trade_z_pkg.sv
// rtl/trade_z_pkg.sv - shared FSM state type and width helpers for the z-score trade engine
package trade_z_pkg;

    // Engine sequencing: one sample walks IDLE -> VAR -> SQRT -> DIV -> CMP -> OUT
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VAR,
        ST_SQRT,
        ST_DIV,
        ST_CMP,
        ST_OUT
    } state_t;

    // Channel id width; a single-channel build still carries a 1-bit id
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Bits needed for a counter spanning 0..max_val (at least 1 bit)
    function automatic int cnt_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/trade_z_engine_isqrt_seq.sv
// rtl/trade_z_engine_isqrt_seq.sv - bit-serial integer square root, one root bit per cycle
module isqrt_seq
    import trade_z_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     root
);

    localparam int CW = cnt_w(DATA_W - 1);

    logic [2*DATA_W-1:0] rad_sh;
    logic [DATA_W:0]     rem;
    logic [CW-1:0]       cnt;
    logic [DATA_W+2:0]   rem_shift;
    logic [DATA_W+2:0]   trial;
    logic                take;
    logic [DATA_W:0]     rem_sub;

    // One iteration: bring down the next radicand bit pair and try root*4+1
    always_comb begin
        rem_shift = {rem, rad_sh[2*DATA_W-1 -: 2]};
        trial     = {1'b0, root, 2'b01};
        take      = (rem_shift >= trial);
        rem_sub   = rem_shift[DATA_W:0] - trial[DATA_W:0];
        done      = busy && (cnt == CW'(DATA_W - 1));
    end

    // Load on start, then iterate exactly DATA_W times; root holds after the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_sh <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            rad_sh <= radicand;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            rad_sh <= rad_sh << 2;
            if (take) begin
                rem  <= rem_sub;
                root <= {root[DATA_W-2:0], 1'b1};
            end else begin
                rem  <= rem_shift[DATA_W:0];
                root <= {root[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trade_z_engine.sv
// rtl/trade_z_engine.sv - sequential multi-channel z-score buy/sell signal engine with cooldown
module trade_z_engine
    import trade_z_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 6,
    parameter int NUM_CH   = 4,
    parameter int Z_THRESH = 128,
    parameter int COOLDOWN = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ch_w(NUM_CH)-1:0]     in_ch,
    input  logic [DATA_W-1:0]           in_price,
    input  logic [DATA_W-1:0]           in_mean,
    input  logic [2*DATA_W-1:0]         in_sqr_mean,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ch_w(NUM_CH)-1:0]     out_ch,
    output logic                        out_buy,
    output logic                        out_sell,
    output logic [2*DATA_W-1:0]         out_z,
    output logic                        out_zero_std
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int CD_W = cnt_w(COOLDOWN);
    localparam int IT_W = cnt_w(2*DATA_W - 1);
    localparam int ZW   = 2*DATA_W;

    state_t state, next_state;

    logic [CH_W-1:0]   ch_r;
    logic [DATA_W-1:0] price_r;
    logic [DATA_W-1:0] mean_r;
    logic [ZW-1:0]     sqr_r;
    logic [IT_W-1:0]   it_cnt;
    logic [ZW-1:0]     div_q;
    logic [DATA_W-1:0] div_r;
    logic [CD_W-1:0]   cd [NUM_CH];

    logic [ZW-1:0]     mean_sq;
    logic [ZW-1:0]     variance;
    logic [DATA_W-1:0] delta;
    logic [ZW-1:0]     dividend;
    logic              sqrt_start;
    logic              sqrt_busy;
    logic              sqrt_done;
    logic [DATA_W-1:0] stddev;
    logic [DATA_W:0]   div_trial;
    logic              div_take;
    logic [DATA_W-1:0] div_sub;
    logic              std_zero;
    logic [ZW-1:0]     z_val;
    logic              hit;
    logic              buy_raw;
    logic              sell_raw;
    logic              cd_active;

    // Variance (clamped at 0), |price-mean| and the fixed-point dividend
    always_comb begin
        mean_sq    = {{DATA_W{1'b0}}, mean_r} * {{DATA_W{1'b0}}, mean_r};
        variance   = (sqr_r >= mean_sq) ? (sqr_r - mean_sq) : '0;
        delta      = (price_r >= mean_r) ? (price_r - mean_r) : (mean_r - price_r);
        dividend   = {{DATA_W{1'b0}}, delta} << FRAC_W;
        sqrt_start = (state == ST_VAR) && !sqrt_busy;
    end

    isqrt_seq #(
        .DATA_W (DATA_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (variance),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (stddev)
    );

    // Restoring divider step plus the threshold / direction / cooldown decision
    always_comb begin
        div_trial = {div_r, div_q[ZW-1]};
        div_take  = (div_trial >= {1'b0, stddev});
        div_sub   = div_trial[DATA_W-1:0] - stddev;
        std_zero  = (stddev == '0);
        z_val     = std_zero ? '0 : div_q;
        hit       = (z_val > ZW'(Z_THRESH));
        buy_raw   = hit && (price_r < mean_r);
        sell_raw  = hit && (price_r > mean_r);
        cd_active = (cd[ch_r] != '0);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and input handshake
    always_comb begin
        next_state = state;
        in_ready   = (state == ST_IDLE) && !rst;
        case (state)
            ST_IDLE: if (in_valid)  next_state = ST_VAR;
            ST_VAR:                 next_state = ST_SQRT;
            ST_SQRT: if (sqrt_done) next_state = ST_DIV;
            ST_DIV:  if (it_cnt == IT_W'(ZW - 1)) next_state = ST_CMP;
            ST_CMP:                 next_state = ST_OUT;
            ST_OUT:  if (out_ready) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    // Sample capture, divider iterations, result registers and per-channel cooldown
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r         <= '0;
            price_r      <= '0;
            mean_r       <= '0;
            sqr_r        <= '0;
            it_cnt       <= '0;
            div_q        <= '0;
            div_r        <= '0;
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out_buy      <= 1'b0;
            out_sell     <= 1'b0;
            out_z        <= '0;
            out_zero_std <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cd[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ch_r    <= in_ch;
                        price_r <= in_price;
                        mean_r  <= in_mean;
                        sqr_r   <= in_sqr_mean;
                    end
                end
                ST_VAR: begin
                    div_q  <= dividend;
                    div_r  <= '0;
                    it_cnt <= '0;
                end
                ST_DIV: begin
                    if (div_take) begin
                        div_r <= div_sub;
                        div_q <= {div_q[ZW-2:0], 1'b1};
                    end else begin
                        div_r <= div_trial[DATA_W-1:0];
                        div_q <= {div_q[ZW-2:0], 1'b0};
                    end
                    it_cnt <= it_cnt + 1'b1;
                end
                ST_CMP: begin
                    out_valid    <= 1'b1;
                    out_ch       <= ch_r;
                    out_z        <= z_val;
                    out_zero_std <= std_zero;
                    if (cd_active) begin
                        out_buy   <= 1'b0;
                        out_sell  <= 1'b0;
                        cd[ch_r]  <= cd[ch_r] - 1'b1;
                    end else begin
                        out_buy  <= buy_raw;
                        out_sell <= sell_raw;
                        if (buy_raw || sell_raw) begin
                            cd[ch_r] <= CD_W'(COOLDOWN);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trade_z_engine.sv
// tb/tb_trade_z_engine.sv - self-checking bench for trade_z_engine against an arithmetic reference model
module tb_trade_z_engine;

    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = '0;
    logic [15:0] in_price = '0;
    logic [15:0] in_mean = '0;
    logic [31:0] in_sqr_mean = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ch;
    logic        out_buy;
    logic        out_sell;
    logic [31:0] out_z;
    logic        out_zero_std;

    int n_cmp = 0;
    int n_bad = 0;
    int cd_m [4];

    longint obs_z;
    bit     obs_buy, obs_sell, obs_zs;

    always #5 clk = ~clk;

    trade_z_engine #(
        .DATA_W   (16),
        .FRAC_W   (6),
        .NUM_CH   (4),
        .Z_THRESH (128),
        .COOLDOWN (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ch        (in_ch),
        .in_price     (in_price),
        .in_mean      (in_mean),
        .in_sqr_mean  (in_sqr_mean),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_buy      (out_buy),
        .out_sell     (out_sell),
        .out_z        (out_z),
        .out_zero_std (out_zero_std)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the statistics, floor sqrt, floor divide, cooldown by sample count
    task automatic ref_model(input int ch, input longint price, input longint mean, input longint sqr,
                             output longint z, output bit buy, output bit sell, output bit zs);
        longint v, sd, d;
        bit hit;
        v = sqr - mean * mean;
        if (v < 0) v = 0;
        sd = longint'($floor($sqrt(real'(v))));
        while (sd * sd > v) sd--;
        while ((sd + 1) * (sd + 1) <= v) sd++;
        d = (price >= mean) ? price - mean : mean - price;
        zs = (sd == 0);
        z = zs ? 0 : (d * 64) / sd;
        hit = (z > 128);
        buy = hit && (price < mean);
        sell = hit && (price > mean);
        if (cd_m[ch] != 0) begin
            buy = 0;
            sell = 0;
            cd_m[ch]--;
        end else if (buy || sell) begin
            cd_m[ch] = CD;
        end
    endtask

    // Accept one sample, time the result, compare it with the model, optionally stall the output
    task automatic run(input int ch, input longint price, input longint mean, input longint sqr,
                       input bit bp);
        longint ez;
        bit eb, es, ezs;
        int n;
        logic [31:0] held_z;
        ref_model(ch, price, mean, sqr, ez, eb, es, ezs);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", longint'(in_ready), 1);
        in_ch = 2'(ch);
        in_price = 16'(price);
        in_mean = 16'(mean);
        in_sqr_mean = 32'(sqr);
        in_valid = 1'b1;
        out_ready = !bp;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_in_ready", longint'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 50);
        check("out_ch", longint'(out_ch), ch);
        check("out_z", longint'(out_z), ez);
        check("out_buy", longint'(out_buy), longint'(eb));
        check("out_sell", longint'(out_sell), longint'(es));
        check("out_zero_std", longint'(out_zero_std), longint'(ezs));
        obs_z = longint'(out_z);
        obs_buy = out_buy;
        obs_sell = out_sell;
        obs_zs = out_zero_std;
        if (bp) begin
            held_z = out_z;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check("bp_valid", longint'(out_valid), 1);
                check("bp_z_stable", longint'(out_z), longint'(held_z));
                check("bp_in_ready", longint'(in_ready), 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("handoff_valid", longint'(out_valid), 0);
        check("handoff_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        int seen;
        longint mn, pr, sq, vr;
        for (int i = 0; i < 4; i++) cd_m[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_z", longint'(out_z), 0);
        check("rst_out_ch", longint'(out_ch), 0);
        check("rst_flags", longint'({out_buy, out_sell, out_zero_std}), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Buy / sell / weak / flat on fresh channels, with absolute expectations
        run(0, 6080, 6400, 40976384, 0);
        check("buy_z160", obs_z, 160);
        check("buy_flag", longint'(obs_buy), 1);
        run(3, 6720, 6400, 40976384, 0);
        check("sell_z160", obs_z, 160);
        check("sell_flag", longint'(obs_sell), 1);
        run(0, 6464, 6400, 40976384, 0);
        check("weak_z32", obs_z, 32);
        check("weak_none", longint'({obs_buy, obs_sell}), 0);
        run(3, 6400, 6400, 40976384, 0);
        check("flat_z0", obs_z, 0);

        // Zero and negative variance
        run(0, 6080, 6400, 40960000, 0);
        check("zero_var_zs", longint'(obs_zs), 1);
        check("zero_var_z", obs_z, 0);
        run(0, 6080, 6400, 40000000, 0);
        check("neg_var_zs", longint'(obs_zs), 1);
        check("neg_var_none", longint'({obs_buy, obs_sell}), 0);

        // Cooldown on ch1 with an interleaved ch2 buy
        run(1, 6080, 6400, 40976384, 0);
        check("cd_1st", longint'(obs_buy), 1);
        run(1, 6080, 6400, 40976384, 0);
        check("cd_2nd", longint'(obs_buy), 0);
        run(2, 6080, 6400, 40976384, 0);
        check("cd_other_ch", longint'(obs_buy), 1);
        run(1, 6080, 6400, 40976384, 0);
        check("cd_3rd", longint'(obs_buy), 0);
        check("cd_3rd_z", obs_z, 160);
        run(1, 6080, 6400, 40976384, 0);
        check("cd_4th", longint'(obs_buy), 1);

        // Output backpressure
        run(3, 6080, 6400, 40976384, 1);

        // Reset in the middle of the square root
        in_ch = 2'd1;
        in_price = 16'd6080;
        in_mean = 16'd6400;
        in_sqr_mean = 32'd40976384;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_in_ready", longint'(in_ready), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cd_m[i] = 0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_output", seen, 0);
        run(1, 6080, 6400, 40976384, 0);
        check("mid_rst_cd_cleared", longint'(obs_buy), 1);

        // Randomized samples
        for (int t = 0; t < 40; t++) begin
            mn = longint'($urandom_range(1000, 60000));
            vr = longint'($urandom_range(0, 1 << 20));
            if ($urandom_range(0, 7) == 0) begin
                sq = mn * mn - vr;
                if (sq < 0) sq = 0;
            end else begin
                sq = mn * mn + vr;
            end
            pr = mn + longint'($urandom_range(0, 4000)) - 2000;
            if ($urandom_range(0, 9) == 0) pr = mn;
            if (pr < 0) pr = 0;
            if (pr > 65535) pr = 65535;
            run(int'($urandom_range(0, 3)), pr, mn, sq, ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
